// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU sequencer: data width, register count,
//   sequencer state encoding and the opcode values driven on alu_op.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 4;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOTINC = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_ADC    = 3'd2;
  localparam logic [2:0] OP_ADDSH  = 3'd3;
  localparam logic [2:0] OP_AND    = 3'd4;
  localparam logic [2:0] OP_OR     = 3'd5;
  localparam logic [2:0] OP_PACK   = 3'd6;
  localparam logic [2:0] OP_LOAD   = 3'd7;

  // Carry is only meaningful to the ALU for add-with-carry.
  function automatic logic fwd_carry(input logic [2:0] op, input logic cin);
    return (op == OP_ADC) ? cin : 1'b0;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
//   NREG x DATA_W register file.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (clears all regs)
//     we, waddr, wdata  single synchronous write port
//     raddr_a/rdata_a   asynchronous read port A
//     raddr_b/rdata_b   asynchronous read port B
//   Reads are combinational, so a read and a write to the same register in
//   the same cycle return the value from before the write.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREG];

  // One flop bank per register, each owning its own write decode.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (waddr == IDX)) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Serialises one instruction at a time onto an external 16-bit ALU.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     instr_valid/instr_ready     instruction handshake
//     instr_op/rd/ra/rb/cin/imm   instruction fields
//     alu_a, alu_b, alu_c, alu_op registered operand drives to the ALU
//     alu_w, alu_zero, alu_neg    ALU result and flags
//     res_valid                   one-cycle commit pulse
//     res_data, res_zero, res_neg last committed value and flags
//   ALU ops take IDLE -> ISSUE -> DONE; LOAD skips ISSUE and goes straight
//   to DONE. res_valid is high exactly while in DONE.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic              instr_cin,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_w,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_neg
);

  state_t            state_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic              alu_c_reg;
  logic [2:0]        alu_op_reg;
  logic              res_valid_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic              res_zero_reg;
  logic              res_neg_reg;

  logic              accept;
  logic              is_load;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  assign instr_ready = (state_reg == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign is_load     = (instr_op == OP_LOAD);

  // Single write per instruction: the immediate at a LOAD accept, or the
  // ALU result at the end of ISSUE. Gating with rst aborts an in-flight op.
  assign rf_we    = !rst && ((accept && is_load) || (state_reg == ISSUE));
  assign rf_waddr = (state_reg == ISSUE) ? rd_reg : instr_rd;
  assign rf_wdata = (state_reg == ISSUE) ? alu_w  : instr_imm;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_ra),
    .rdata_a (rf_rdata_a),
    .raddr_b (instr_rb),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rd_reg        <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_c_reg     <= 1'b0;
      alu_op_reg    <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_zero_reg  <= 1'b0;
      res_neg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          res_valid_reg <= 1'b0;
          if (accept) begin
            if (is_load) begin
              res_data_reg  <= instr_imm;
              res_zero_reg  <= (instr_imm == '0);
              res_neg_reg   <= instr_imm[DATA_W-1];
              res_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              rd_reg     <= instr_rd;
              alu_a_reg  <= rf_rdata_a;
              alu_b_reg  <= rf_rdata_b;
              alu_op_reg <= instr_op;
              alu_c_reg  <= fwd_carry(instr_op, instr_cin);
              state_reg  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          res_data_reg  <= alu_w;
          res_zero_reg  <= alu_zero;
          res_neg_reg   <= alu_neg;
          res_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          res_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          res_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_c     = alu_c_reg;
  assign alu_op    = alu_op_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_zero  = res_zero_reg;
  assign res_neg   = res_neg_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a behavioural 16-bit ALU attached.
//   ALU behaviour: NOTINC ~a+1, INC a+1, ADC a+b+c, ADDSH a+(b>>1),
//   AND, OR, PACK {a[7:0],b[7:0]}; zero/neg flags derived from the result.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [1:0]  instr_rd, instr_ra, instr_rb;
  logic        instr_cin;
  logic [15:0] instr_imm;
  logic [15:0] alu_a, alu_b;
  logic        alu_c;
  logic [2:0]  alu_op;
  logic [15:0] alu_w;
  logic        alu_zero, alu_neg;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_zero, res_neg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_cin   (instr_cin),
    .instr_imm   (instr_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_op      (alu_op),
    .alu_w       (alu_w),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_neg     (res_neg)
  );

  // Behavioural ALU
  always_comb begin
    alu_w = '0;
    case (alu_op)
      3'd0:    alu_w = ~alu_a + 16'd1;
      3'd1:    alu_w = alu_a + 16'd1;
      3'd2:    alu_w = alu_a + alu_b + {15'd0, alu_c};
      3'd3:    alu_w = alu_a + (alu_b >> 1);
      3'd4:    alu_w = alu_a & alu_b;
      3'd5:    alu_w = alu_a | alu_b;
      3'd6:    alu_w = {alu_a[7:0], alu_b[7:0]};
      default: alu_w = '0;
    endcase
  end
  assign alu_zero = (alu_w == 16'd0);
  assign alu_neg  = alu_w[15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input logic cin, input logic [15:0] imm);
    instr_op  = op;
    instr_rd  = rd;
    instr_ra  = ra;
    instr_rb  = rb;
    instr_cin = cin;
    instr_imm = imm;
  endtask

  // Called at a negedge. Offers one instruction, waits for accept, captures
  // the ALU drives one cycle after accept, then counts cycles to res_valid.
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                      input logic [1:0] rb, input logic cin, input logic [15:0] imm,
                      output int lat, output logic [15:0] ia, output logic [15:0] ib,
                      output logic ic, output logic [2:0] iop);
    int waitc;
    set_instr(op, rd, ra, rb, cin, imm);
    instr_valid = 1'b1;
    waitc = 0;
    lat = 0; ia = '0; ib = '0; ic = 1'b0; iop = '0;
    while (!instr_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    ia  = alu_a;
    ib  = alu_b;
    ic  = alu_c;
    iop = alu_op;
    lat = 1;
    while (!res_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // After a committed result: one-cycle pulse, then back to a negedge in IDLE.
  task automatic pulse_end(input string tag);
    @(negedge clk);
    check(tag, {31'd0, res_valid}, 32'd0);
  endtask

  int          lat;
  logic [15:0] ia, ib;
  logic        ic;
  logic [2:0]  iop;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    set_instr(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",     {31'd0, instr_ready}, 32'd0);
    check("rst_alu_a",     {16'd0, alu_a}, 32'd0);
    check("rst_alu_b",     {16'd0, alu_b}, 32'd0);
    check("rst_alu_c",     {31'd0, alu_c}, 32'd0);
    check("rst_alu_op",    {29'd0, alu_op}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  {16'd0, res_data}, 32'd0);
    check("rst_res_zero",  {31'd0, res_zero}, 32'd0);
    check("rst_res_neg",   {31'd0, res_neg}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);

    // LOAD
    send(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h1234, lat, ia, ib, ic, iop);
    check("load1_lat",  lat, 32'd1);
    check("load1_data", {16'd0, res_data}, 32'h1234);
    check("load1_zero", {31'd0, res_zero}, 32'd0);
    check("load1_neg",  {31'd0, res_neg}, 32'd0);
    pulse_end("load1_pulse_end");
    send(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h8000, lat, ia, ib, ic, iop);
    check("load2_data", {16'd0, res_data}, 32'h8000);
    check("load2_neg",  {31'd0, res_neg}, 32'd1);
    pulse_end("load2_pulse_end");

    // ADDSH r3 = r1 + (r2>>1), r1=3, r2=4 -> 5
    send(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'd3, lat, ia, ib, ic, iop);
    pulse_end("load3_pulse_end");
    send(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'd4, lat, ia, ib, ic, iop);
    pulse_end("load4_pulse_end");
    send(3'd3, 2'd3, 2'd1, 2'd2, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("addsh_alu_a",  {16'd0, ia}, 32'd3);
    check("addsh_alu_b",  {16'd0, ib}, 32'd4);
    check("addsh_alu_op", {29'd0, iop}, 32'd3);
    check("addsh_lat",    lat, 32'd2);
    check("addsh_data",   {16'd0, res_data}, 32'd5);
    check("addsh_zero",   {31'd0, res_zero}, 32'd0);
    pulse_end("addsh_pulse_end");
    send(3'd5, 2'd0, 2'd3, 2'd3, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("r3_readback", {16'd0, res_data}, 32'd5);
    pulse_end("or_pulse_end");

    // ADC r3 = 0xFFFF + 0x0000 + 1 -> 0, zero
    send(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'hFFFF, lat, ia, ib, ic, iop);
    pulse_end("load5_pulse_end");
    send(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000, lat, ia, ib, ic, iop);
    check("load_zero_flag", {31'd0, res_zero}, 32'd1);
    pulse_end("load6_pulse_end");
    send(3'd2, 2'd3, 2'd1, 2'd2, 1'b1, 16'd0, lat, ia, ib, ic, iop);
    check("adc_alu_c", {31'd0, ic}, 32'd1);
    check("adc_lat",   lat, 32'd2);
    check("adc_data",  {16'd0, res_data}, 32'h0000);
    check("adc_zero",  {31'd0, res_zero}, 32'd1);
    pulse_end("adc_pulse_end");
    check("alu_c_held", {31'd0, alu_c}, 32'd1);

    // rd == ra: pre-write value is read. 0xFFFF + 0x7FFF = 0x7FFE
    send(3'd3, 2'd1, 2'd1, 2'd1, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("self_alu_a", {16'd0, ia}, 32'hFFFF);
    check("self_data",  {16'd0, res_data}, 32'h7FFE);
    pulse_end("self_pulse_end");

    // AND with cin=1: carry not forwarded
    send(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 16'h00F0, lat, ia, ib, ic, iop);
    pulse_end("load7_pulse_end");
    send(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0FFF, lat, ia, ib, ic, iop);
    pulse_end("load8_pulse_end");
    send(3'd4, 2'd0, 2'd1, 2'd2, 1'b1, 16'd0, lat, ia, ib, ic, iop);
    check("and_alu_c",  {31'd0, ic}, 32'd0);
    check("and_alu_op", {29'd0, iop}, 32'd4);
    check("and_data",   {16'd0, res_data}, 32'h00F0);
    pulse_end("and_pulse_end");

    // NOTINC r3 = ~0x0FFF + 1 = 0xF001; PACK; INC r0 = 0x00F1
    send(3'd0, 2'd3, 2'd2, 2'd0, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("notinc_data", {16'd0, res_data}, 32'hF001);
    check("notinc_neg",  {31'd0, res_neg}, 32'd1);
    pulse_end("notinc_pulse_end");
    send(3'd6, 2'd3, 2'd1, 2'd2, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("pack_data", {16'd0, res_data}, 32'hF0FF);
    pulse_end("pack_pulse_end");
    send(3'd1, 2'd0, 2'd0, 2'd0, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("inc_data", {16'd0, res_data}, 32'h00F1);
    pulse_end("inc_pulse_end");

    // Back-to-back with instr_valid held high
    begin
      logic [2:0]  b_op  [4];
      logic [1:0]  b_rd  [4];
      logic [1:0]  b_ra  [4];
      logic [1:0]  b_rb  [4];
      logic [15:0] b_imm [4];
      logic [15:0] got   [4];
      logic [15:0] expd  [4];
      int acc [4];
      int k, pulses;
      b_op[0] = 3'd7; b_rd[0] = 2'd0; b_ra[0] = 2'd0; b_rb[0] = 2'd0; b_imm[0] = 16'h0011;
      b_op[1] = 3'd7; b_rd[1] = 2'd1; b_ra[1] = 2'd0; b_rb[1] = 2'd0; b_imm[1] = 16'h0022;
      b_op[2] = 3'd5; b_rd[2] = 2'd2; b_ra[2] = 2'd0; b_rb[2] = 2'd1; b_imm[2] = 16'h0000;
      b_op[3] = 3'd7; b_rd[3] = 2'd3; b_ra[3] = 2'd0; b_rb[3] = 2'd0; b_imm[3] = 16'h0044;
      expd[0] = 16'h0011; expd[1] = 16'h0022; expd[2] = 16'h0033; expd[3] = 16'h0044;
      for (int i = 0; i < 4; i++) begin
        acc[i] = -1;
        got[i] = '0;
      end
      k = 0;
      pulses = 0;
      set_instr(b_op[0], b_rd[0], b_ra[0], b_rb[0], 1'b0, b_imm[0]);
      instr_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (res_valid) begin
          if (pulses < 4) got[pulses] = res_data;
          pulses++;
          check("b2b_ready_in_done", {31'd0, instr_ready}, 32'd0);
        end
        if (k >= 3 && cyc == acc[2] + 1)
          check("b2b_ready_in_issue", {31'd0, instr_ready}, 32'd0);
        if (instr_ready && k < 4) begin
          acc[k] = cyc;
          k++;
        end
        @(posedge clk);
        @(negedge clk);
        if (k < 4) set_instr(b_op[k], b_rd[k], b_ra[k], b_rb[k], 1'b0, b_imm[k]);
        else instr_valid = 1'b0;
      end
      check("b2b_accepts", k, 32'd4);
      check("b2b_pulses",  pulses, 32'd4);
      check("b2b_gap_0_1", acc[1] - acc[0], 32'd2);
      check("b2b_gap_1_2", acc[2] - acc[1], 32'd2);
      check("b2b_gap_2_3", acc[3] - acc[2], 32'd3);
      for (int i = 0; i < 4; i++)
        check($sformatf("b2b_data%0d", i), {16'd0, got[i]}, {16'd0, expd[i]});
    end

    // Reset during ISSUE of AND r0 = r1 & r2
    begin
      int seen;
      set_instr(3'd4, 2'd0, 2'd1, 2'd2, 1'b0, 16'd0);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("abort_in_issue_ready", {31'd0, instr_ready}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        if (res_valid) seen++;
        @(negedge clk);
      end
      check("abort_no_pulse", seen, 32'd0);
      check("abort_res_data", {16'd0, res_data}, 32'd0);
    end
    send(3'd5, 2'd3, 2'd0, 2'd1, 1'b0, 16'd0, lat, ia, ib, ic, iop);
    check("abort_r0_alu_a", {16'd0, ia}, 32'd0);
    check("abort_r0_data",  {16'd0, res_data}, 32'd0);
    check("abort_r0_zero",  {31'd0, res_zero}, 32'd1);
    pulse_end("abort_or_pulse_end");
    send(3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 16'hBEEF, lat, ia, ib, ic, iop);
    check("post_abort_lat",  lat, 32'd1);
    check("post_abort_data", {16'd0, res_data}, 32'hBEEF);
    check("post_abort_neg",  {31'd0, res_neg}, 32'd1);
    pulse_end("post_abort_pulse_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr_ready  out  1  instruction accepted on a clk edge where both instr_valid and instr_ready are high.
REQ-006 instr_op  in  3  opcode: 0 NOTINC, 1 INC, 2 ADC, 3 ADDSH, 4 AND, 5 OR, 6 PACK, 7 LOAD.
REQ-007 instr_rd, instr_ra, instr_rb  in  2 each  destination and source register indices.
REQ-008 instr_cin  in  1  carry-in, forwarded only for ADC.
REQ-009 instr_imm  in  16  immediate, used only for LOAD.
REQ-010 alu_a, alu_b  out  16  operand drives to the 16-bit ALU.
REQ-011 alu_c  out  1  carry drive; alu_op  out  3  opcode drive.
REQ-012 alu_w  in  16  ALU result; alu_zero, alu_neg  in  1 each  ALU flags.
REQ-013 res_valid  out  1  one-cycle pulse when a result is committed.
REQ-014 res_data  out  16  committed value; res_zero, res_neg  out  1 each  committed flags.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and DONE; instr_ready = (state==IDLE) && !rst.
REQ-016 IDLE, on accept with op 0-6: latch rd; register alu_a=R[ra], alu_b=R[rb], alu_op=op, alu_c=(op==2)?cin:0; go to ISSUE.
REQ-017 IDLE, on accept with op 7: write R[rd]=imm; res_data=imm, res_zero=(imm==0), res_neg=imm[15]; go to DONE; alu_* outputs unchanged.
REQ-018 ISSUE lasts exactly one cycle; at its closing edge: R[rd]=alu_w, res_data=alu_w, res_zero=alu_zero, res_neg=alu_neg; go to DONE.
REQ-019 DONE lasts exactly one cycle with res_valid=1, then returns to IDLE; res_valid=0 in all other states.
REQ-020 Latency from accept edge to res_valid: ALU ops 2 cycles, LOAD 1 cycle; peak throughput one instruction per 3 (ALU) or 2 (LOAD) cycles.
REQ-021 alu_a, alu_b, alu_c and alu_op SHALL hold their last values outside ISSUE.
REQ-022 res_data, res_zero and res_neg SHALL hold their values until the next commit.
REQ-023 Register file: 4 x 16 bits; reads at the accept edge; exactly one write per instruction.
REQ-024 Because instructions are serialized, no hazards exist; ra or rb equal to rd SHALL read the pre-write value.
REQ-025 instr_* inputs SHALL be ignored unless accepted; a held instr_valid while not ready SHALL cause no state change.
REQ-026 res_valid has no backpressure; the consumer SHALL sample it on the pulse.

Reset
REQ-027 rst SHALL set state=IDLE, all R[i]=0, alu_a=alu_b=0, alu_c=0, alu_op=0, res_valid=0, res_data=0, res_zero=0, res_neg=0.
REQ-028 rst asserted in ISSUE or DONE SHALL abort the instruction: no register write, no res_valid; rst takes priority over every other event.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the state enum, the OP_* opcode constants (0-7), DATA_W=16 and NREG=4.
REQ-030 One sub-module, alu_seq_regfile (4x16, two asynchronous read ports, one synchronous write port, synchronous reset), SHALL be instantiated.

Verification
REQ-031 Reset: after rst, all outputs are 0 and instr_ready=1 on the first cycle after rst deasserts.
REQ-032 LOAD r1=0x1234 -> res_valid one cycle after accept, res_data=0x1234, res_zero=0, res_neg=0; LOAD r2=0x8000 -> res_neg=1.
REQ-033 Connect the team's 16-bit ALU; with r1=3 and r2=4, issue ADDSH rd=3 ra=1 rb=2 -> alu_a=3 and alu_b=4 in ISSUE; res_data=5 two cycles after accept; R3=5.
REQ-034 ADC r3=r1+r2 with cin=1 and r1=0xFFFF, r2=0x0000 -> alu_c=1; res_data=0x0000 and res_zero=1.
REQ-035 Hold instr_valid high with back-to-back instructions -> instr_ready is low in ISSUE and DONE; each instruction is accepted only in IDLE, and no instruction is lost or duplicated.
REQ-036 Assert rst during ISSUE of AND r0=r1&r2 -> no res_valid pulse; R0 reads 0 afterwards; the next LOAD completes normally.
